rf_write_arbiter: RTL and testbench

Sequential arbiter that shares the register file's single write port (WE3/WA3/WD3) between the pipeline writeback stage and the multi-cycle multiply unit. Writeback has priority by default. A saturating wait counter bounds multiplier starvation by stalling writeback once the multiplier has waited MAX_WAIT cycles. Outputs are registered and drive the register file directly. The register file writes on the following falling edge.

---
 rtl/rf_write_arbiter_if.sv | 25 ++
 rtl/rf_write_arbiter.sv | 71 +++++++
 tb/tb_rf_write_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Bundle for the register file write port arbiter: writeback and multiply requests in,
// handshake responses and the registered WE3/WA3/WD3 write port out.
interface rf_write_arbiter_if;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mul_valid;
  logic [3:0]  mul_addr;
  logic [31:0] mul_data;
  logic        mul_ready;
  logic        stall_w;
  logic        WE3;
  logic [3:0]  WA3;
  logic [31:0] WD3;

  modport master (
    output wb_valid, wb_addr, wb_data, mul_valid, mul_addr, mul_data,
    input  mul_ready, stall_w, WE3, WA3, WD3
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mul_valid, mul_addr, mul_data,
    output mul_ready, stall_w, WE3, WA3, WD3
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the single register file write port between writeback (default priority) and the
// multiplier; grant is combinational, WE3/WA3/WD3 follow one cycle later. Refused writeback sees stall_w.
module rf_write_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave bus
);

  localparam int unsigned    CW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          we_q, we_d;
  logic [3:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;

  logic          grant_mul;
  logic          grant_wb;
  logic [3:0]    sel_addr;
  logic [31:0]   sel_data;

  always_comb begin
    grant_mul = bus.mul_valid && (!bus.wb_valid || (wait_cnt_q == MAX_CNT));
    grant_wb  = bus.wb_valid && !grant_mul;
    sel_addr  = grant_mul ? bus.mul_addr : bus.wb_addr;
    sel_data  = grant_mul ? bus.mul_data : bus.wb_data;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant_mul || !bus.mul_valid) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_CNT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // r15 is the PC: a granted write there still consumes the slot but never asserts WE3.
  always_comb begin
    we_d = (grant_mul || grant_wb) && (sel_addr != 4'hF);
    wa_d = wa_q;
    wd_d = wd_q;
    if (grant_mul || grant_wb) begin
      wa_d = sel_addr;
      wd_d = sel_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      wa_q       <= 4'h0;
      wd_q       <= 32'h0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
    end
  end

  assign bus.mul_ready = grant_mul;
  assign bus.stall_w   = bus.wb_valid && grant_mul;
  assign bus.WE3       = we_q;
  assign bus.WA3       = wa_q;
  assign bus.WD3       = wd_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table for single-cycle arbitration plus
// hand sequences for starvation, same-address collision and asynchronous reset.
module tb_rf_write_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] rf [16];

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: captures on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'h0;
    end else if (bus.WE3) begin
      rf[bus.WA3] <= bus.WD3;
    end
  end

  typedef struct {
    logic        wv;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [3:0]  ma;
    logic [31:0] md;
    logic        e_rdy;
    logic        e_stall;
    logic        e_we;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [3:0] ma, input logic [31:0] md);
    @(negedge clk);
    bus.wb_valid  = wv;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.mul_valid = mv;
    bus.mul_addr  = ma;
    bus.mul_data  = md;
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic e_rdy, input logic e_stall);
    chk({tag, ".mul_ready"}, {31'h0, bus.mul_ready}, {31'h0, e_rdy});
    chk({tag, ".stall_w"},   {31'h0, bus.stall_w},   {31'h0, e_stall});
  endtask

  task automatic chk_reg(input string tag, input logic e_we, input logic [3:0] e_wa,
                         input logic [31:0] e_wd);
    @(posedge clk);
    #1;
    chk({tag, ".WE3"}, {31'h0, bus.WE3}, {31'h0, e_we});
    chk({tag, ".WA3"}, {28'h0, bus.WA3}, {28'h0, e_wa});
    chk({tag, ".WD3"}, bus.WD3, e_wd);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = 4'h0;
    bus.wb_data   = 32'h0;
    bus.mul_valid = 1'b0;
    bus.mul_addr  = 4'h0;
    bus.mul_data  = 32'h0;

    //         wv  wa     wd            mv  ma     md            rdy  stl  we   wa     wd
    vecs[0] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b0,4'h0, 32'h0};
    vecs[1] = '{1'b1, 4'h3, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b1,4'h3, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 4'h0, 32'h0,        1'b1, 4'h7, 32'h12345678, 1'b1,1'b0,1'b1,4'h7, 32'h12345678};
    vecs[3] = '{1'b1, 4'hF, 32'hAAAA5555, 1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b0,4'hF, 32'hAAAA5555};
    vecs[4] = '{1'b0, 4'h0, 32'h0,        1'b1, 4'hF, 32'h0BADF00D, 1'b1,1'b0,1'b0,4'hF, 32'h0BADF00D};
    vecs[5] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b0,4'hF, 32'h0BADF00D};
    vecs[6] = '{1'b1, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b1,4'h0, 32'h0};
    vecs[7] = '{1'b1, 4'hE, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h0,        1'b0,1'b0,1'b1,4'hE, 32'hFFFFFFFF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst.WE3", {31'h0, bus.WE3}, 32'h0);
    chk("rst.WA3", {28'h0, bus.WA3}, 32'h0);
    chk("rst.WD3", bus.WD3, 32'h0);
    chk("rst.wait_cnt", 32'(dut.wait_cnt_q), 32'h0);
    chk_comb("rst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].mv, vecs[i].ma, vecs[i].md);
      chk_comb($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_stall);
      chk_reg($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd);
    end
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("rf3", rf[3], 32'hDEADBEEF);
    chk("rf7", rf[7], 32'h12345678);
    chk("rf14", rf[14], 32'hFFFFFFFF);
    chk("rf15", rf[15], 32'h0);

    // Starvation: multiplier loses cycles 0-3, wins cycle 4, held writeback goes at cycle 5.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 4'(c + 1), 32'h100 + c, 1'b1, 4'h9, 32'h99990000);
      chk_comb($sformatf("starve%0d", c), 1'b0, 1'b0);
      chk_reg($sformatf("starve%0d", c), 1'b1, 4'(c + 1), 32'h100 + c);
      chk($sformatf("starve%0d.wait_cnt", c), 32'(dut.wait_cnt_q), c + 1);
    end
    drive(1'b1, 4'h5, 32'h104, 1'b1, 4'h9, 32'h99990000);
    chk_comb("starve4", 1'b1, 1'b1);
    chk_reg("starve4", 1'b1, 4'h9, 32'h99990000);
    chk("starve4.wait_cnt", 32'(dut.wait_cnt_q), 32'h0);
    drive(1'b1, 4'h5, 32'h104, 1'b0, 4'h0, 32'h0);
    chk_comb("starve5", 1'b0, 1'b0);
    chk_reg("starve5", 1'b1, 4'h5, 32'h104);
    chk("starve5.wait_cnt", 32'(dut.wait_cnt_q), 32'h0);

    // Same-address collision on r2: writeback first, multiplier overwrites next cycle.
    drive(1'b1, 4'h2, 32'h22220000, 1'b1, 4'h2, 32'h33330001);
    chk_comb("coll0", 1'b0, 1'b0);
    chk_reg("coll0", 1'b1, 4'h2, 32'h22220000);
    drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h2, 32'h33330001);
    chk("coll.rf2_first", rf[2], 32'h22220000);
    chk_comb("coll1", 1'b1, 1'b0);
    chk_reg("coll1", 1'b1, 4'h2, 32'h33330001);
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    chk("coll.rf2_final", rf[2], 32'h33330001);

    // Asynchronous reset mid-cycle while WE3 is high and a multiplier request is waiting.
    drive(1'b1, 4'h6, 32'h66666666, 1'b1, 4'h8, 32'h88888888);
    @(posedge clk);
    #3;
    chk("arst.pre_WE3", {31'h0, bus.WE3}, 32'h1);
    reset = 1'b1;
    #1;
    chk("arst.WE3", {31'h0, bus.WE3}, 32'h0);
    chk("arst.WA3", {28'h0, bus.WA3}, 32'h0);
    chk("arst.WD3", bus.WD3, 32'h0);
    chk("arst.wait_cnt", 32'(dut.wait_cnt_q), 32'h0);
    @(posedge clk);
    #1;
    chk("arst.held_WE3", {31'h0, bus.WE3}, 32'h0);
    chk("arst.held_WD3", bus.WD3, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_comb("arst.rel", 1'b0, 1'b0);
    chk_reg("arst.rel", 1'b1, 4'h6, 32'h66666666);
    chk("arst.rel.wait_cnt", 32'(dut.wait_cnt_q), 32'h1);

    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
